reveal_mem_arbiter: RTL

Owns the single write port of the 256-entry reveal memory (16x16 grid, address {y[3:0], x[3:0]}, 1 bit per cell) and shares it between the new-game clear sweep, the first-click 3x3 opener, and two stallable requesters (flood-fill engine and player click logic). It sits between those engines and the reveal RAM, registers the selected write, and reports clear progress to game state control.

---
 rtl/reveal_mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/reveal_mem_arbiter.sv
// Reveal memory write-port arbiter: new-game clear sweep, first-click opener, flood-fill (A) and player click (B).
// Latency: one cycle from an accepted write to mem_addr/mem_in/mem_wren; a clear occupies 256 consecutive write cycles.
// Backpressure: A/B hold req until gnt (combinational); the opener cannot stall, so any opener write during a clear is dropped and flagged.
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   clear_req / clear_busy / clear_done   clear sweep control and progress
//   sw_wren, sw_addr, sw_in        opener write (no grant)
//   a_req, a_addr, a_in, a_gnt     flood-fill write request/grant
//   b_req, b_addr, b_in, b_gnt     player click write request/grant
//   drop_err                       sticky flag: opener write lost during clear
//   mem_addr, mem_in, mem_wren     registered reveal RAM write port
module reveal_mem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              sw_wren,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic              sw_in,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_in,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_in,
    output logic              b_gnt,
    output logic              drop_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_in,
    output logic              mem_wren
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    // 0: A wins the next A/B tie, 1: B wins it
    logic              rr_q, rr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_in_q, mem_in_d;
    logic              mem_wren_q, mem_wren_d;
    logic              clear_busy_q, clear_busy_d;
    logic              clear_done_q, clear_done_d;
    logic              drop_err_q, drop_err_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        mem_addr_d   = mem_addr_q;
        mem_in_d     = mem_in_q;
        mem_wren_d   = 1'b0;
        clear_done_d = 1'b0;
        drop_err_d   = drop_err_q;
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    // The port is handed to the sweep immediately; nothing else
                    // is written this cycle, so a concurrent opener write is lost.
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    if (sw_wren) begin
                        drop_err_d = 1'b1;
                    end
                end else if (sw_wren) begin
                    mem_wren_d = 1'b1;
                    mem_addr_d = sw_addr;
                    mem_in_d   = sw_in;
                end else if (a_req && (!b_req || !rr_q)) begin
                    a_gnt      = 1'b1;
                    mem_wren_d = 1'b1;
                    mem_addr_d = a_addr;
                    mem_in_d   = a_in;
                    rr_d       = 1'b1;
                end else if (b_req) begin
                    b_gnt      = 1'b1;
                    mem_wren_d = 1'b1;
                    mem_addr_d = b_addr;
                    mem_in_d   = b_in;
                    rr_d       = 1'b0;
                end
            end
            ST_CLEAR: begin
                mem_wren_d = 1'b1;
                mem_addr_d = cnt_q;
                mem_in_d   = 1'b0;
                // Wraps to zero on the final write, leaving the counter ready
                // for the next sweep.
                cnt_d      = cnt_q + 1'b1;
                if (sw_wren) begin
                    drop_err_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d      = ST_IDLE;
                    clear_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        clear_busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rr_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_in_q     <= 1'b0;
            mem_wren_q   <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            mem_addr_q   <= mem_addr_d;
            mem_in_q     <= mem_in_d;
            mem_wren_q   <= mem_wren_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_in     = mem_in_q;
    assign mem_wren   = mem_wren_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;
    assign drop_err   = drop_err_q;

endmodule
